// File: rtl/strip_controller.sv
// LED strip frame sequencer: fetches 24-bit pixels, drives a bit generator, then latches.
// Optional STRIP_CTRL_GRB_SWAP_EN reorders incoming {R,G,B} pixels to {G,R,B} on latch.
module strip_controller #(
  parameter int NUM_LEDS   = 8,
  parameter int RET_CYCLES = 5000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [23:0] pixData,
  input  logic        pixValid,
  output logic        pixReady,
  output logic [7:0]  ledIndex,
  output logic [1:0]  genMode,
  output logic        doGen,
  input  logic        genDone,
  output logic        busy,
  output logic        frameDone
);

  localparam int CW = $clog2(RET_CYCLES) + 1;
  localparam logic [7:0]    LAST_LED = 8'(NUM_LEDS - 1);
  localparam logic [CW-1:0] RET_LAST = CW'(RET_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SHIFT,
    GAP,
    RET,
    DONE
  } state_e;

  state_e        state_q;
  logic [23:0]   shreg_q;
  logic [4:0]    bitCnt_q;
  logic [CW-1:0] retCnt_q;
  logic [7:0]    ledIndex_q;
  logic [1:0]    genMode_q;
  logic          doGen_q;
  logic          pixReady_q;
  logic          busy_q;
  logic          frameDone_q;
  logic [23:0]   pix_d;

`ifdef STRIP_CTRL_GRB_SWAP_EN
  assign pix_d = {pixData[15:8], pixData[23:16], pixData[7:0]};
`else
  assign pix_d = pixData;
`endif

  // Outputs are loaded on the edge that enters the state they belong to.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      bitCnt_q    <= '0;
      retCnt_q    <= '0;
      ledIndex_q  <= '0;
      genMode_q   <= 2'b00;
      doGen_q     <= 1'b0;
      pixReady_q  <= 1'b0;
      busy_q      <= 1'b0;
      frameDone_q <= 1'b0;
    end else begin
      frameDone_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= FETCH;
            ledIndex_q <= '0;
            pixReady_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        FETCH: begin
          if (pixValid) begin
            state_q    <= SHIFT;
            shreg_q    <= pix_d;
            bitCnt_q   <= 5'd23;
            pixReady_q <= 1'b0;
            doGen_q    <= 1'b1;
            genMode_q  <= {~pix_d[23], pix_d[23]};
          end
        end
        SHIFT: begin
          if (genDone) begin
            state_q   <= GAP;
            doGen_q   <= 1'b0;
            genMode_q <= 2'b00;
          end
        end
        GAP: begin
          shreg_q <= shreg_q << 1;
          if (bitCnt_q != 5'd0) begin
            state_q   <= SHIFT;
            bitCnt_q  <= bitCnt_q - 5'd1;
            doGen_q   <= 1'b1;
            genMode_q <= {~shreg_q[22], shreg_q[22]};
          end else if (ledIndex_q < LAST_LED) begin
            state_q    <= FETCH;
            ledIndex_q <= ledIndex_q + 8'd1;
            pixReady_q <= 1'b1;
          end else begin
            state_q  <= RET;
            retCnt_q <= '0;
          end
        end
        RET: begin
          if (retCnt_q == RET_LAST) begin
            state_q     <= DONE;
            retCnt_q    <= '0;
            frameDone_q <= 1'b1;
          end else begin
            retCnt_q <= retCnt_q + 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q    <= IDLE;
          doGen_q    <= 1'b0;
          genMode_q  <= 2'b00;
          pixReady_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign pixReady  = pixReady_q;
  assign ledIndex  = ledIndex_q;
  assign genMode   = genMode_q;
  assign doGen     = doGen_q;
  assign busy      = busy_q;
  assign frameDone = frameDone_q;

endmodule

// File: tb/tb_strip_controller.sv
// Scoreboard bench for strip_controller: expected bit codes are queued per pixel
// handshake and popped as the controller presents each bit.
module tb_strip_controller;

  localparam int N  = 4;
  localparam int RC = 5000;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [23:0] pixData;
  logic        pixValid;
  logic        genDone;
  logic        pixReady;
  logic [7:0]  ledIndex;
  logic [1:0]  genMode;
  logic        doGen;
  logic        busy;
  logic        frameDone;

  int vectors = 0;
  int miscompares = 0;
  logic [1:0]  exp_q[$];
  logic [23:0] pix_tbl[N];

  strip_controller #(.NUM_LEDS(N), .RET_CYCLES(RC)) u_dut (
    .clk(clk), .reset(reset), .start(start),
    .pixData(pixData), .pixValid(pixValid),
    .pixReady(pixReady), .ledIndex(ledIndex),
    .genMode(genMode), .doGen(doGen), .genDone(genDone),
    .busy(busy), .frameDone(frameDone)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] model_latch(input logic [23:0] p);
`ifdef STRIP_CTRL_GRB_SWAP_EN
    return {p[15:8], p[23:16], p[7:0]};
`else
    return p;
`endif
  endfunction

  task automatic push_pixel(input logic [23:0] p);
    logic [23:0] q;
    q = model_latch(p);
    for (int i = 23; i >= 0; i--)
      exp_q.push_back(q[i] ? 2'b01 : 2'b10);
  endtask

  task automatic send_frame(input int hold_led, input int abort_led);
    logic [1:0] exp;
    int k;
    bit seen;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int led = 0; led < N; led++) begin
      vectors++;
      if (pixReady !== 1'b1 || doGen !== 1'b0 || ledIndex !== 8'(led)) begin
        miscompares++;
        $display("FAIL fetch led%0d: rdy=%b doGen=%b idx=%0d, want 1 0 %0d",
                 led, pixReady, doGen, ledIndex, led);
      end
      if (led == hold_led) begin
        for (int c = 0; c < 500; c++) begin
          genDone = (c % 50 == 7);
          @(negedge clk);
          vectors++;
          if (pixReady !== 1'b1 || doGen !== 1'b0 || ledIndex !== 8'(led)) begin
            miscompares++;
            $display("FAIL stall c%0d: rdy=%b doGen=%b idx=%0d, want 1 0 %0d",
                     c, pixReady, doGen, ledIndex, led);
          end
        end
        genDone = 1'b0;
      end
      pixData = pix_tbl[led];
      pixValid = 1'b1;
      push_pixel(pix_tbl[led]);
      @(negedge clk);
      pixValid = 1'b0;
      pixData = 24'($urandom);
      for (int b = 0; b < 24; b++) begin
        if (led == abort_led && b == 5) begin
          #2 reset = 1'b0;
          #1;
          vectors++;
          if (doGen !== 1'b0 || busy !== 1'b0 || pixReady !== 1'b0 ||
              genMode !== 2'b00 || ledIndex !== 8'd0 || frameDone !== 1'b0) begin
            miscompares++;
            $display("FAIL abort: doGen=%b busy=%b rdy=%b mode=%b idx=%0d fd=%b, want all 0",
                     doGen, busy, pixReady, genMode, ledIndex, frameDone);
          end
          exp_q.delete();
          @(negedge clk);
          reset = 1'b1;
          for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            vectors++;
            if (busy !== 1'b0 || frameDone !== 1'b0 || doGen !== 1'b0) begin
              miscompares++;
              $display("FAIL post_abort c%0d: busy=%b fd=%b doGen=%b, want 0 0 0",
                       c, busy, frameDone, doGen);
            end
          end
          return;
        end
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 2'b11;
        vectors++;
        if (doGen !== 1'b1 || genMode !== exp) begin
          miscompares++;
          $display("FAIL bit led%0d b%0d: doGen=%b mode=%b, want 1 %b",
                   led, b, doGen, genMode, exp);
        end
        for (int w = 0; w < (b % 3); w++) begin
          @(negedge clk);
          vectors++;
          if (doGen !== 1'b1 || genMode !== exp) begin
            miscompares++;
            $display("FAIL bit_hold led%0d b%0d: doGen=%b mode=%b, want 1 %b",
                     led, b, doGen, genMode, exp);
          end
        end
        genDone = 1'b1;
        @(negedge clk);
        genDone = 1'b0;
        vectors++;
        if (doGen !== 1'b0 || genMode !== 2'b00 || pixReady !== 1'b0 || busy !== 1'b1) begin
          miscompares++;
          $display("FAIL gap led%0d b%0d: doGen=%b mode=%b rdy=%b busy=%b, want 0 00 0 1",
                   led, b, doGen, genMode, pixReady, busy);
        end
        @(negedge clk);
      end
    end
    k = 1;
    seen = 1'b0;
    while (k <= RC + 1000) begin
      if (frameDone === 1'b1) begin
        seen = 1'b1;
        break;
      end
      vectors++;
      if (doGen !== 1'b0 || genMode !== 2'b00 || pixReady !== 1'b0 || busy !== 1'b1) begin
        miscompares++;
        $display("FAIL ret k%0d: doGen=%b mode=%b rdy=%b busy=%b, want 0 00 0 1",
                 k, doGen, genMode, pixReady, busy);
      end
      start = (k == 100);
      genDone = (k == 200);
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    genDone = 1'b0;
    vectors++;
    if (!seen || k != RC + 1) begin
      miscompares++;
      $display("FAIL done_time: seen=%b at %0d cycles after last gap, want %0d",
               seen, k, RC + 1);
    end
    @(negedge clk);
    vectors++;
    if (frameDone !== 1'b0 || busy !== 1'b0 || ledIndex !== 8'(N - 1)) begin
      miscompares++;
      $display("FAIL done_pulse: fd=%b busy=%b idx=%0d, want 0 0 %0d",
               frameDone, busy, ledIndex, N - 1);
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      vectors++;
      if (busy !== 1'b0 || pixReady !== 1'b0 || ledIndex !== 8'(N - 1)) begin
        miscompares++;
        $display("FAIL idle_hold c%0d: busy=%b rdy=%b idx=%0d, want 0 0 %0d",
                 c, busy, pixReady, ledIndex, N - 1);
      end
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard: %0d bits left, want 0", exp_q.size());
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    start = 1'b0;
    pixValid = 1'b0;
    pixData = '0;
    genDone = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (doGen !== 1'b0 || genMode !== 2'b00 || pixReady !== 1'b0 || busy !== 1'b0 ||
        frameDone !== 1'b0 || ledIndex !== 8'd0) begin
      miscompares++;
      $display("FAIL reset: doGen=%b mode=%b rdy=%b busy=%b fd=%b idx=%0d, want all 0",
               doGen, genMode, pixReady, busy, frameDone, ledIndex);
    end
    reset = 1'b1;
    genDone = 1'b1;
    @(negedge clk);
    genDone = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      vectors++;
      if (busy !== 1'b0 || doGen !== 1'b0 || pixReady !== 1'b0) begin
        miscompares++;
        $display("FAIL idle_gendone c%0d: busy=%b doGen=%b rdy=%b, want 0 0 0",
                 c, busy, doGen, pixReady);
      end
    end
  endtask

  task automatic test_pattern;
    pix_tbl[0] = 24'hA50000;
    pix_tbl[1] = 24'h0000FF;
    pix_tbl[2] = 24'hFF0000;
    pix_tbl[3] = 24'h5A3C0F;
    send_frame(-1, -1);
  endtask

  task automatic test_fetch_stall;
    for (int i = 0; i < N; i++)
      pix_tbl[i] = 24'($urandom);
    send_frame(1, -1);
  endtask

  task automatic test_reset_mid_frame;
    for (int i = 0; i < N; i++)
      pix_tbl[i] = 24'($urandom);
    send_frame(-1, 3);
    send_frame(-1, -1);
  endtask

  initial begin
    test_reset;
    test_pattern;
    test_fetch_stall;
    test_reset_mid_frame;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, %0d miscompares so far",
             miscompares);
    $fatal(1, "timeout");
  end

endmodule
